// File: rtl/axi_user_arb.sv
// Two-master round-robin arbiter in front of the axi_rw user port.
// Holds one registered request per grant and inserts a dead cycle after each completion.
module axi_user_arb #(
   parameter int ADDR_W = 64,
   parameter int DATA_W = 512,
   parameter int BLKS_W = 8
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              m0_valid,
   input  logic              m0_op,
   input  logic [ADDR_W-1:0] m0_addr,
   input  logic [1:0]        m0_size,
   input  logic [BLKS_W-1:0] m0_blks,
   input  logic [DATA_W-1:0] m0_wdata,
   output logic              m0_ready,
   output logic [DATA_W-1:0] m0_rdata,
   output logic [1:0]        m0_resp,
   input  logic              m1_valid,
   input  logic              m1_op,
   input  logic [ADDR_W-1:0] m1_addr,
   input  logic [1:0]        m1_size,
   input  logic [BLKS_W-1:0] m1_blks,
   input  logic [DATA_W-1:0] m1_wdata,
   output logic              m1_ready,
   output logic [DATA_W-1:0] m1_rdata,
   output logic [1:0]        m1_resp,
   output logic              out_valid,
   output logic              out_op,
   output logic [ADDR_W-1:0] out_addr,
   output logic [1:0]        out_size,
   output logic [BLKS_W-1:0] out_blks,
   output logic [DATA_W-1:0] out_wdata,
   input  logic              in_ready,
   input  logic [DATA_W-1:0] in_rdata,
   input  logic [1:0]        in_resp
);

   typedef enum logic [1:0] {IDLE, BUSY0, BUSY1, DONE} state_t;

   state_t state;
   logic   last_grant;
   logic   tie;
   logic   gnt0;
   logic   gnt1;

   // last_grant only moves on a tie; a lone requester never shifts priority
   always_comb begin
      tie  = m0_valid & m1_valid;
      gnt0 = m0_valid & (~m1_valid | last_grant);
      gnt1 = m1_valid & (~m0_valid | ~last_grant);
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state      <= IDLE;
         last_grant <= 1'b1;
         out_valid  <= 1'b0;
         out_op     <= 1'b0;
         out_addr   <= '0;
         out_size   <= '0;
         out_blks   <= '0;
         out_wdata  <= '0;
         m0_ready   <= 1'b0;
         m0_rdata   <= '0;
         m0_resp    <= '0;
         m1_ready   <= 1'b0;
         m1_rdata   <= '0;
         m1_resp    <= '0;
      end else begin
         m0_ready <= 1'b0;
         m1_ready <= 1'b0;
         unique case (state)
            IDLE: begin
               unique case (1'b1)
                  gnt0: begin
                     out_valid <= 1'b1;
                     out_op    <= m0_op;
                     out_addr  <= m0_addr;
                     out_size  <= m0_size;
                     out_blks  <= m0_blks;
                     out_wdata <= m0_wdata;
                     state     <= BUSY0;
                     if (tie) last_grant <= 1'b0;
                  end
                  gnt1: begin
                     out_valid <= 1'b1;
                     out_op    <= m1_op;
                     out_addr  <= m1_addr;
                     out_size  <= m1_size;
                     out_blks  <= m1_blks;
                     out_wdata <= m1_wdata;
                     state     <= BUSY1;
                     if (tie) last_grant <= 1'b1;
                  end
                  default: ;
               endcase
            end
            BUSY0: begin
               if (in_ready) begin
                  m0_rdata  <= in_rdata;
                  m0_resp   <= in_resp;
                  m0_ready  <= 1'b1;
                  out_valid <= 1'b0;
                  state     <= DONE;
               end
            end
            BUSY1: begin
               if (in_ready) begin
                  m1_rdata  <= in_rdata;
                  m1_resp   <= in_resp;
                  m1_ready  <= 1'b1;
                  out_valid <= 1'b0;
                  state     <= DONE;
               end
            end
            DONE:    state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_axi_user_arb.sv
// Scoreboard bench for axi_user_arb: grants and completions are queued
// when driven and checked by a negedge monitor.
module tb_axi_user_arb;

   localparam int AW = 64;
   localparam int DW = 512;
   localparam int BW = 8;

   logic          clock = 1'b0;
   logic          reset = 1'b1;
   logic          m0_valid = 1'b0, m0_op = 1'b0;
   logic [AW-1:0] m0_addr = '0;
   logic [1:0]    m0_size = '0;
   logic [BW-1:0] m0_blks = '0;
   logic [DW-1:0] m0_wdata = '0;
   logic          m0_ready;
   logic [DW-1:0] m0_rdata;
   logic [1:0]    m0_resp;
   logic          m1_valid = 1'b0, m1_op = 1'b0;
   logic [AW-1:0] m1_addr = '0;
   logic [1:0]    m1_size = '0;
   logic [BW-1:0] m1_blks = '0;
   logic [DW-1:0] m1_wdata = '0;
   logic          m1_ready;
   logic [DW-1:0] m1_rdata;
   logic [1:0]    m1_resp;
   logic          out_valid, out_op;
   logic [AW-1:0] out_addr;
   logic [1:0]    out_size;
   logic [BW-1:0] out_blks;
   logic [DW-1:0] out_wdata;
   logic          in_ready = 1'b0;
   logic [DW-1:0] in_rdata = '0;
   logic [1:0]    in_resp = '0;

   axi_user_arb #(.ADDR_W(AW), .DATA_W(DW), .BLKS_W(BW)) dut (
      .clock(clock), .reset(reset),
      .m0_valid(m0_valid), .m0_op(m0_op), .m0_addr(m0_addr),
      .m0_size(m0_size), .m0_blks(m0_blks), .m0_wdata(m0_wdata),
      .m0_ready(m0_ready), .m0_rdata(m0_rdata), .m0_resp(m0_resp),
      .m1_valid(m1_valid), .m1_op(m1_op), .m1_addr(m1_addr),
      .m1_size(m1_size), .m1_blks(m1_blks), .m1_wdata(m1_wdata),
      .m1_ready(m1_ready), .m1_rdata(m1_rdata), .m1_resp(m1_resp),
      .out_valid(out_valid), .out_op(out_op), .out_addr(out_addr),
      .out_size(out_size), .out_blks(out_blks), .out_wdata(out_wdata),
      .in_ready(in_ready), .in_rdata(in_rdata), .in_resp(in_resp)
   );

   always #5 clock = ~clock;

   typedef struct {
      logic          op;
      logic [AW-1:0] addr;
      logic [1:0]    size;
      logic [BW-1:0] blks;
      logic [DW-1:0] wdata;
   } req_t;

   typedef struct {
      int            who;
      logic [DW-1:0] rd;
      logic [1:0]    rs;
   } cpl_t;

   req_t gq[$];
   cpl_t cq[$];
   int   total = 0;
   int   bad = 0;
   logic ov_prev = 1'b0;

   task automatic chk(input string tag, input logic [DW-1:0] got,
                      input logic [DW-1:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   always @(negedge clock) begin
      req_t e;
      cpl_t c;
      if (!reset) begin
         if (out_valid && !ov_prev) begin
            if (gq.size() == 0) chk("unexp_grant", 1, 0);
            else begin
               e = gq.pop_front();
               chk("g_op", out_op, e.op);
               chk("g_addr", out_addr, e.addr);
               chk("g_size", out_size, e.size);
               chk("g_blks", out_blks, e.blks);
               chk("g_wdata", out_wdata, e.wdata);
            end
         end
         if (m0_ready || m1_ready) begin
            chk("one_ready", m0_ready & m1_ready, 0);
            if (cq.size() == 0) chk("unexp_ready", 1, 0);
            else begin
               c = cq.pop_front();
               chk("c_who", m1_ready ? 1 : 0, c.who);
               chk("c_rdata", m1_ready ? m1_rdata : m0_rdata, c.rd);
               chk("c_resp", m1_ready ? m1_resp : m0_resp, c.rs);
            end
         end
      end
      ov_prev <= reset ? 1'b0 : out_valid;
   end

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic wait_ov(input string tag, input int exp_lat);
      int n = 0;
      while (!out_valid && n < 20) begin
         tick();
         n++;
      end
      if (!out_valid) chk({tag, "_timeout"}, 0, 1);
      else chk({tag, "_lat"}, n, exp_lat);
   endtask

   task automatic serve(input int who, input logic [DW-1:0] rd,
                        input logic [1:0] rs, input int lat);
      cpl_t c;
      repeat (lat) tick();
      c.who = who; c.rd = rd; c.rs = rs;
      cq.push_back(c);
      in_rdata = rd;
      in_resp  = rs;
      in_ready = 1'b1;
      tick();
      in_ready = 1'b0;
      chk("done_ov", out_valid, 0);
      chk("other_ready", (who == 1) ? m0_ready : m1_ready, 0);
   endtask

   function automatic req_t mk(input logic op, input logic [AW-1:0] a,
                               input logic [1:0] s, input logic [BW-1:0] b,
                               input logic [DW-1:0] w);
      req_t r;
      r.op = op; r.addr = a; r.size = s; r.blks = b; r.wdata = w;
      return r;
   endfunction

   task automatic drive(input int who, input req_t r);
      if (who == 0) begin
         m0_op = r.op; m0_addr = r.addr; m0_size = r.size;
         m0_blks = r.blks; m0_wdata = r.wdata; m0_valid = 1'b1;
      end else begin
         m1_op = r.op; m1_addr = r.addr; m1_size = r.size;
         m1_blks = r.blks; m1_wdata = r.wdata; m1_valid = 1'b1;
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [DW-1:0] pa, pb, pc;
      req_t r0, r1;
      pa = {16{32'hA5A5_0001}};
      pb = {16{32'hB00B_1234}};
      pc = {16{32'h0C0C_7777}};

      // reset state
      tick(); tick();
      chk("rst_ov", out_valid, 0);
      chk("rst_addr", out_addr, 0);
      chk("rst_m0rdy", m0_ready, 0);
      chk("rst_m1rdy", m1_ready, 0);
      chk("rst_m0rd", m0_rdata, 0);
      chk("rst_m1rs", m1_resp, 0);
      reset = 1'b0;
      tick();

      // single m0 read
      r0 = mk(1'b0, 64'h8000_0000, 2'd3, 8'd7, '0);
      drive(0, r0); gq.push_back(r0);
      wait_ov("t1", 1);
      chk("t1_addr", out_addr, 64'h8000_0000);
      serve(0, pa, 2'b00, 2);
      tick();
      m0_valid = 1'b0;
      chk("t1_pulse_end", m0_ready, 0);
      tick();

      // round robin: tie, then loser, then re-asserting master
      reset = 1'b1; tick(); reset = 1'b0; tick();
      r0 = mk(1'b0, 64'h1000, 2'd2, 8'd3, '0);
      r1 = mk(1'b0, 64'h2000, 2'd1, 8'd1, '0);
      drive(0, r0); drive(1, r1);
      gq.push_back(r0);
      wait_ov("t2a", 1);
      serve(0, pa, 2'b00, 1);
      tick();
      m0_valid = 1'b0;
      gq.push_back(r1);
      wait_ov("t2b_gap", 1);
      r0 = mk(1'b0, 64'h3000, 2'd3, 8'd0, '0);
      drive(0, r0); gq.push_back(r0);
      serve(1, pb, 2'b01, 1);
      tick();
      m1_valid = 1'b0;
      wait_ov("t2c_gap", 1);
      serve(0, pc, 2'b00, 0);
      tick();
      m0_valid = 1'b0;
      tick();

      // m1 write, request changes while busy
      r1 = mk(1'b1, 64'h8000_1000, 2'd3, 8'd0, pb);
      drive(1, r1); gq.push_back(r1);
      wait_ov("t3", 1);
      m1_addr = '0; m1_wdata = '0; m1_op = 1'b0;
      tick(); tick(); tick();
      chk("t3_hold_ov", out_valid, 1);
      chk("t3_hold_addr", out_addr, 64'h8000_1000);
      chk("t3_hold_wd", out_wdata, pb);
      chk("t3_hold_op", out_op, 1);
      serve(1, pa, 2'b10, 0);
      chk("t3_m0_keep", m0_rdata, pc);
      tick();
      m1_valid = 1'b0;
      tick();

      // stray in_ready in IDLE
      in_ready = 1'b1; in_rdata = pa; in_resp = 2'b11;
      tick();
      in_ready = 1'b0;
      chk("t4_ov", out_valid, 0);
      chk("t4_m0rdy", m0_ready, 0);
      chk("t4_m1rdy", m1_ready, 0);
      tick();
      chk("t4_m1rs", m1_resp, 2'b10);

      // async reset while BUSY0
      r0 = mk(1'b0, 64'h9000, 2'd1, 8'd2, '0);
      drive(0, r0); gq.push_back(r0);
      wait_ov("t5", 1);
      tick();
      #3 reset = 1'b1;
      #1;
      chk("t5_ov", out_valid, 0);
      chk("t5_m0rdy", m0_ready, 0);
      chk("t5_addr", out_addr, 0);
      chk("t5_m0rd", m0_rdata, 0);
      @(posedge clock); #1;
      reset = 1'b0;
      r1 = mk(1'b0, 64'hA000, 2'd2, 8'd5, '0);
      drive(1, r1);
      gq.push_back(r0);
      wait_ov("t5_regrant", 1);
      serve(0, pb, 2'b00, 1);
      tick();
      m0_valid = 1'b0;
      gq.push_back(r1);
      wait_ov("t5_m1", 1);
      serve(1, pc, 2'b01, 1);
      tick();
      m1_valid = 1'b0;
      tick();

      // m0 held continuously: 1..1, 0 (DONE), 0 (IDLE), 1
      r0 = mk(1'b0, 64'hB000, 2'd3, 8'd1, '0);
      drive(0, r0); gq.push_back(r0); gq.push_back(r0);
      wait_ov("t6", 1);
      serve(0, pa, 2'b00, 1);
      tick();
      chk("t6_idle_ov", out_valid, 0);
      tick();
      chk("t6_regrant_ov", out_valid, 1);
      serve(0, pc, 2'b00, 1);
      tick();
      m0_valid = 1'b0;
      tick(); tick();
      chk("t6_quiet_ov", out_valid, 0);

      chk("gq_empty", gq.size(), 0);
      chk("cq_empty", cq.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
